ram_port_sequencer: RTL

- Owns the single port of the 64 KB main RAM array and sequences three users: a fill engine, the Oric core bus (ram_ad/ram_d/ram_we/ram_cs), and the HPS ioctl loader.
- Fill engine: after reset, writes FILL to every location before the core is released.
- Run mode: the core has absolute priority. Loader writes go through a 1-deep buffer and retire in idle slots, throttled by ioctl_wait.
- Sits between the oricatmos instance and the inferred RAM in emu.

---
 rtl/ram_port_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_port_sequencer.sv
// Single-port owner of the main RAM array: clears it with FILL after reset, then
// arbitrates between the core (absolute priority) and a 1-deep loader write buffer.
module ram_port_sequencer #(
  parameter int              AW        = 16,
  parameter int              DW        = 8,
  parameter logic [DW-1:0]   FILL      = 8'hFF,
  parameter logic [15:0]     LOAD_BASE = 16'h0000
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ad,
  input  logic [DW-1:0] cpu_d,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_hold,
  input  logic          ld_wr,
  input  logic [24:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ioctl_wait,
  output logic          ld_ovf,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q,
  output logic          fill_done
);

  typedef enum logic { ST_FILL, ST_RUN } state_t;
  typedef enum logic { OWN_NONE, OWN_CPU } owner_t;

  localparam logic [AW-1:0] FCNT_LAST = '1;
  localparam logic [AW-1:0] BASE      = AW'(LOAD_BASE);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_fcnt;
  logic          r_buf_full;
  logic [AW-1:0] r_buf_a;
  logic [DW-1:0] r_buf_d;
  logic          r_ovf;
  logic          r_fill_done;
  logic [DW-1:0] r_q_hold;
  owner_t        r_owner_d1;
  owner_t        w_owner;
  logic          w_retire;
  logic          w_capture;
  logic          w_drop;
  logic          w_unused_ld_hi;

  // Loader addresses alias modulo the array size.
  assign w_unused_ld_hi = ^ld_addr[24:AW];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_FILL;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    ram_a       = cpu_ad;
    ram_din     = cpu_d;
    ram_we      = 1'b0;
    w_owner     = OWN_NONE;
    w_retire    = 1'b0;
    case (r_state)
      ST_FILL: begin
        ram_a   = r_fcnt;
        ram_din = FILL;
        ram_we  = 1'b1;
        if (r_fcnt == FCNT_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cpu_cs) begin
          ram_we  = cpu_we;
          w_owner = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (r_buf_full) begin
          ram_a    = r_buf_a;
          ram_din  = r_buf_d;
          ram_we   = 1'b1;
          w_retire = 1'b1;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
    if (reset) begin
      ram_we   = 1'b0;
      w_retire = 1'b0;
    end
  end

  // A capture in the retire cycle refills the buffer, so ioctl_wait never dips.
  assign w_capture = ld_wr && (!r_buf_full || w_retire);
  assign w_drop    = ld_wr && r_buf_full && !w_retire;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_fcnt      <= '0;
      r_buf_full  <= 1'b0;
      r_ovf       <= 1'b0;
      r_fill_done <= 1'b0;
      r_q_hold    <= '0;
      r_owner_d1  <= OWN_NONE;
    end else begin
      if (r_state == ST_FILL) begin
        r_fcnt <= r_fcnt + AW'(1);
        if (r_fcnt == FCNT_LAST) r_fill_done <= 1'b1;
      end
      if (w_capture)     r_buf_full <= 1'b1;
      else if (w_retire) r_buf_full <= 1'b0;
      if (w_drop) r_ovf <= 1'b1;
      r_owner_d1 <= w_owner;
      if (r_owner_d1 == OWN_CPU) r_q_hold <= ram_q;
    end
  end

  // NOTE: buffer payload is only meaningful while r_buf_full is set, so it
  // carries no reset and needs no reset fan-out.
  always_ff @(posedge clk_sys) begin
    if (w_capture) begin
      r_buf_a <= BASE + ld_addr[AW-1:0];
      r_buf_d <= ld_data;
    end
  end

  assign cpu_q      = (r_owner_d1 == OWN_CPU) ? ram_q : r_q_hold;
  assign cpu_hold   = (r_state == ST_FILL);
  assign ioctl_wait = r_buf_full;
  assign ld_ovf     = r_ovf;
  assign fill_done  = r_fill_done;

endmodule
